// File: rtl/tern_dot_sequencer_pkg.sv
// rtl/tern_dot_sequencer_pkg.sv - shared types and defaults for the ternary dot-product sequencer
package tern_pkg;

  localparam int TERN_LANES  = 16;
  localparam int TERN_DATA_W = 8;
  localparam int TERN_LEN_W  = 13;
  localparam int TERN_ADDR_W = 8;
  localparam int TERN_ACC_W  = 21;

  // 2'b10 is reserved and treated exactly like zero
  typedef enum logic [1:0] {
    TERN_ZERO = 2'b00,
    TERN_POS  = 2'b01,
    TERN_RSVD = 2'b10,
    TERN_NEG  = 2'b11
  } tern_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/tern_dot_sequencer_if.sv
// rtl/tern_dot_sequencer_if.sv - controller, buffer and result signals of the sequencer
interface tern_dot_sequencer_if #(
  parameter int LANES  = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 13,
  parameter int ADDR_W = 8,
  parameter int ACC_W  = 21
);
  logic                      start;
  logic [LEN_W-1:0]          len;
  logic                      busy;
  logic                      rd_en;
  logic [ADDR_W-1:0]         rd_addr;
  logic [LANES*DATA_W-1:0]   act_data;
  logic [LANES*2-1:0]        wgt_data;
  logic [ACC_W-1:0]          result;
  logic                      result_valid;
  logic                      result_ready;

  // sequencer side
  modport master (
    input  start, len, act_data, wgt_data, result_ready,
    output busy, rd_en, rd_addr, result, result_valid
  );

  // controller / buffer side
  modport slave (
    output start, len, act_data, wgt_data, result_ready,
    input  busy, rd_en, rd_addr, result, result_valid
  );
endinterface

// File: rtl/tern_lane_sum.sv
// rtl/tern_lane_sum.sv - two-stage ternary multiply and lane reduction for one chunk
module tern_lane_sum
  import tern_pkg::*;
#(
  parameter int LANES  = TERN_LANES,
  parameter int DATA_W = TERN_DATA_W,
  parameter int ACC_W  = TERN_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  input  logic                    in_last_i,
  input  logic [LANES-1:0]        mask_i,
  input  logic [LANES*DATA_W-1:0] act_i,
  input  logic [LANES*2-1:0]      wgt_i,
  output logic                    sum_valid_o,
  output logic                    sum_last_o,
  output logic [ACC_W-1:0]        sum_o
);

  logic [LANES-1:0][ACC_W-1:0] ext_w;
  logic [LANES-1:0][ACC_W-1:0] pos_q;
  logic [LANES-1:0][ACC_W-1:0] neg_q;
  tern_t [LANES-1:0]           code_q;
  logic [LANES-1:0]            mask_q;
  logic                        s1_valid_q, s1_last_q;
  logic [ACC_W-1:0]            sum_d, sum_q;
  logic                        s2_valid_q, s2_last_q;

  // sign-extend each activation to accumulator width so -(-128) stays +128
  always_comb begin
    ext_w = '0;
    for (int i = 0; i < LANES; i++) begin
      ext_w[i] = {{(ACC_W-DATA_W){act_i[i*DATA_W+DATA_W-1]}}, act_i[i*DATA_W+:DATA_W]};
    end
  end

  // stage 1: register both signs of every activation alongside its code and lane mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q      <= '0;
      neg_q      <= '0;
      code_q     <= '0;
      mask_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        pos_q[i]  <= ext_w[i];
        neg_q[i]  <= '0 - ext_w[i];
        code_q[i] <= tern_t'(wgt_i[2*i+:2]);
      end
      mask_q     <= mask_i;
      s1_valid_q <= in_valid_i;
      s1_last_q  <= in_last_i;
    end
  end

  // select per lane by weight code and reduce; masked lanes and zero/reserved codes add nothing
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask_q[i]) begin
        case (code_q[i])
          TERN_POS: sum_d = sum_d + pos_q[i];
          TERN_NEG: sum_d = sum_d + neg_q[i];
          default:  sum_d = sum_d;
        endcase
      end
    end
  end

  // stage 2: register the chunk sum with its valid/last tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q      <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_valid_q & s1_last_q;
    end
  end

  assign sum_o       = sum_q;
  assign sum_valid_o = s2_valid_q;
  assign sum_last_o  = s2_last_q;

endmodule

// File: rtl/tern_dot_sequencer.sv
// rtl/tern_dot_sequencer.sv - chunked ternary dot product: read sequencing, accumulation, result handshake
module tern_dot_sequencer
  import tern_pkg::*;
#(
  parameter int LANES  = TERN_LANES,
  parameter int DATA_W = TERN_DATA_W,
  parameter int LEN_W  = TERN_LEN_W,
  parameter int ADDR_W = TERN_ADDR_W,
  parameter int ACC_W  = TERN_ACC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  tern_dot_sequencer_if.master  bus
);

  localparam int LG    = $clog2(LANES);
  localparam int CNT_W = LEN_W - LG;

  seq_state_t        state_q;
  logic              busy_q, rd_en_q, result_valid_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [CNT_W-1:0]  rem_q;
  logic [LANES-1:0]  tail_mask_q, issue_mask_q, dmask_q;
  logic              issue_last_q, dv_q, dlast_q;
  logic [ACC_W-1:0]  acc_q, acc_d, result_q;

  logic [LG-1:0]     len_rem_w;
  logic [CNT_W-1:0]  chunks_w;
  logic [LANES-1:0]  tail_mask_w;
  logic              sum_valid_w, sum_last_w;
  logic [ACC_W-1:0]  sum_w;

  // chunk count and the lane mask of the final (possibly partial) chunk
  always_comb begin
    len_rem_w = bus.len[LG-1:0];
    chunks_w  = bus.len[LEN_W-1:LG] + CNT_W'(|len_rem_w);
    for (int i = 0; i < LANES; i++) begin
      tail_mask_w[i] = (len_rem_w == '0) || (LG'(i) < len_rem_w);
    end
  end

  tern_lane_sum #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_lane_sum (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (dv_q),
    .in_last_i   (dlast_q),
    .mask_i      (dmask_q),
    .act_i       (bus.act_data),
    .wgt_i       (bus.wgt_data),
    .sum_valid_o (sum_valid_w),
    .sum_last_o  (sum_last_w),
    .sum_o       (sum_w)
  );

  assign acc_d = acc_q + sum_w;

  // sequencer FSM: issue C chunk reads, track tags into the data cycle, accumulate, hold result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      busy_q         <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      rem_q          <= '0;
      tail_mask_q    <= '0;
      issue_mask_q   <= '0;
      issue_last_q   <= 1'b0;
      dv_q           <= 1'b0;
      dmask_q        <= '0;
      dlast_q        <= 1'b0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      // buffers answer one cycle after rd_en, so tags follow the strobe by one cycle
      dv_q    <= rd_en_q;
      dmask_q <= issue_mask_q;
      dlast_q <= rd_en_q & issue_last_q;
      if (sum_valid_w) acc_q <= acc_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            acc_q  <= '0;
            if (bus.len == '0) begin
              result_q       <= '0;
              result_valid_q <= 1'b1;
              state_q        <= ST_DONE;
            end else begin
              rd_en_q      <= 1'b1;
              rd_addr_q    <= '0;
              rem_q        <= chunks_w - CNT_W'(1);
              tail_mask_q  <= tail_mask_w;
              issue_last_q <= (chunks_w == CNT_W'(1));
              issue_mask_q <= (chunks_w == CNT_W'(1)) ? tail_mask_w : '1;
              state_q      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (rem_q == '0) begin
            rd_en_q      <= 1'b0;
            issue_last_q <= 1'b0;
            state_q      <= ST_DRAIN;
          end else begin
            rd_addr_q    <= rd_addr_q + ADDR_W'(1);
            rem_q        <= rem_q - CNT_W'(1);
            issue_last_q <= (rem_q == CNT_W'(1));
            issue_mask_q <= (rem_q == CNT_W'(1)) ? tail_mask_q : '1;
          end
        end
        ST_DRAIN: begin
          if (sum_valid_w && sum_last_w) begin
            result_q       <= acc_d;
            result_valid_q <= 1'b1;
            state_q        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;

endmodule
